// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, FSM encoding, reset PC.
package fetch_stage_pkg;

   localparam logic [6:0]  BRANCH = 7'b1100011;
   localparam logic [6:0]  JALR   = 7'b1100111;
   localparam logic [6:0]  SYSTEM = 7'b1110011;

   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      BR_WAIT = 2'd1,
      HOLD    = 2'd2
   } fetch_state_t;

   function automatic logic is_branch(input logic [31:0] ir);
      return ir[6:0] == BRANCH;
   endfunction

endpackage

// File: rtl/fetch_stage_pc_mux.sv
// Next-PC select for fetch (trap > branch resolve > increment > hold) with redirect alignment check.
module fetch_pc_mux #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] pc,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            br_resolve,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            advance,
   output logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            redirect,
   output logic            misalign
);

   always_comb begin
      pc_plus4 = pc + XLEN'(4);
      next_pc  = pc;
      redirect = 1'b0;
      if (trap) begin
         next_pc  = trap_vec;
         redirect = 1'b1;
      end else if (br_resolve && br_taken) begin
         next_pc  = br_target;
         redirect = 1'b1;
      end else if (advance) begin
         next_pc  = pc_plus4;
      end
      // Only meaningful when redirect is set; non-taken resolves keep PC (already branch PC+4).
      misalign = next_pc[1:0] != 2'b00;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues IMEM requests and loads the DE latches for decode.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int             XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic            CLK,
   input  logic            RESET,
   output logic            IMEM_REQ,
   output logic [XLEN-1:0] IMEM_ADDR,
   input  logic            IMEM_RDY,
   input  logic [31:0]     IMEM_DATA,
   input  logic            V_MEM_STALL,
   input  logic            V_DE_BR_STALL,
   input  logic            BR_RESOLVE,
   input  logic            BR_TAKEN,
   input  logic [XLEN-1:0] BR_TARGET,
   input  logic            DE_CS,
   input  logic [XLEN-1:0] DE_MTVEC,
   output logic [XLEN-1:0] DE_NPC,
   output logic [31:0]     DE_IR,
   output logic            DE_V,
   output logic            FETCH_MISALIGN
);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc, next_pc, pc_plus4;
   logic [31:0]     hold_ir, load_word;
   logic            misalign_q, redirect, tgt_misalign;
   logic            load_de, capture_hold, bubble, br_res_v;

   // Combinational gate on RESET keeps the request low for the whole reset window.
   assign IMEM_REQ       = !RESET && (state == FETCH) && !misalign_q;
   assign IMEM_ADDR      = pc;
   assign FETCH_MISALIGN = misalign_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      load_de      = 1'b0;
      load_word    = IMEM_DATA;
      capture_hold = 1'b0;
      bubble       = 1'b0;
      br_res_v     = 1'b0;
      if (DE_CS) begin
         state_nxt = FETCH;
         bubble    = 1'b1;
      end else begin
         case (state)
            FETCH: begin
               if (misalign_q) begin
                  bubble = 1'b1;
               end else if (IMEM_RDY) begin
                  if (V_MEM_STALL) begin
                     capture_hold = 1'b1;
                     state_nxt    = HOLD;
                  end else begin
                     load_de   = 1'b1;
                     state_nxt = is_branch(IMEM_DATA) ? BR_WAIT : FETCH;
                  end
               end else if (!V_MEM_STALL) begin
                  bubble = 1'b1;
               end
            end
            HOLD: begin
               if (!V_MEM_STALL) begin
                  load_de   = 1'b1;
                  load_word = hold_ir;
                  state_nxt = is_branch(hold_ir) ? BR_WAIT : FETCH;
               end
            end
            BR_WAIT: begin
               if (!V_MEM_STALL) bubble = 1'b1;
               if (BR_RESOLVE) begin
                  br_res_v  = 1'b1;
                  state_nxt = FETCH;
               end
            end
            default: state_nxt = FETCH;
         endcase
      end
   end

   fetch_pc_mux #(.XLEN(XLEN)) u_pc_mux (
      .pc         (pc),
      .trap       (DE_CS),
      .trap_vec   (DE_MTVEC),
      .br_resolve (br_res_v),
      .br_taken   (BR_TAKEN),
      .br_target  (BR_TARGET),
      .advance    (load_de),
      .next_pc    (next_pc),
      .pc_plus4   (pc_plus4),
      .redirect   (redirect),
      .misalign   (tgt_misalign)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pc         <= RESET_PC;
         DE_NPC     <= '0;
         DE_IR      <= '0;
         DE_V       <= 1'b0;
         hold_ir    <= '0;
         misalign_q <= 1'b0;
      end else begin
         pc <= next_pc;
         if (load_de) begin
            DE_IR  <= load_word;
            DE_NPC <= pc_plus4;
            DE_V   <= 1'b1;
         end else if (bubble) begin
            DE_V   <= 1'b0;
         end
         if (capture_hold) hold_ir    <= IMEM_DATA;
         if (redirect)     misalign_q <= tgt_misalign;
      end
   end

   // Decode only holds a branch while fetch is waiting on its resolution.
   a_br_stall: assert property (@(posedge CLK) disable iff (RESET)
      V_DE_BR_STALL |-> (state == BR_WAIT));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset corner sequence, then random traffic vs a reference model.
module tb_fetch_stage;

   logic        CLK = 1'b0, RESET = 1'b1;
   logic        IMEM_REQ, IMEM_RDY = 1'b0;
   logic [63:0] IMEM_ADDR;
   logic [31:0] IMEM_DATA = '0;
   logic        V_MEM_STALL = 1'b0, V_DE_BR_STALL = 1'b0;
   logic        BR_RESOLVE = 1'b0, BR_TAKEN = 1'b0, DE_CS = 1'b0;
   logic [63:0] BR_TARGET = '0, DE_MTVEC = '0;
   logic [63:0] DE_NPC;
   logic [31:0] DE_IR;
   logic        DE_V, FETCH_MISALIGN;

   always #5 CLK = ~CLK;

   fetch_stage #(.XLEN(64), .RESET_PC(64'h1000)) dut (
      .CLK(CLK), .RESET(RESET), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
      .IMEM_RDY(IMEM_RDY), .IMEM_DATA(IMEM_DATA), .V_MEM_STALL(V_MEM_STALL),
      .V_DE_BR_STALL(V_DE_BR_STALL), .BR_RESOLVE(BR_RESOLVE), .BR_TAKEN(BR_TAKEN),
      .BR_TARGET(BR_TARGET), .DE_CS(DE_CS), .DE_MTVEC(DE_MTVEC), .DE_NPC(DE_NPC),
      .DE_IR(DE_IR), .DE_V(DE_V), .FETCH_MISALIGN(FETCH_MISALIGN)
   );

   localparam logic [31:0] I1 = 32'h0010_0093;
   localparam logic [31:0] I2 = 32'h0020_0113;
   localparam logic [31:0] I3 = 32'h0030_0193;
   localparam logic [31:0] BR = 32'h0000_0063;

   typedef struct {
      logic        rdy;  logic [31:0] data; logic stall;
      logic        brr;  logic brt;  logic [63:0] tgt;
      logic        cs;   logic [63:0] mtvec;
      logic [63:0] e_addr; logic e_req; logic e_v;
      logic [31:0] e_ir;   logic [63:0] e_npc; logic e_mis;
   } vec_t;

   vec_t tv[$];
   int   n_vec = 0, n_bad = 0;

   function automatic vec_t mk(input logic rdy, input logic [31:0] d, input logic st,
                               input logic brr, input logic brt, input logic [63:0] tgt,
                               input logic cs, input logic [63:0] mt,
                               input logic [63:0] ea, input logic er, input logic ev,
                               input logic [31:0] eir, input logic [63:0] enpc, input logic em);
      vec_t v;
      v.rdy = rdy; v.data = d; v.stall = st; v.brr = brr; v.brt = brt; v.tgt = tgt;
      v.cs = cs; v.mtvec = mt; v.e_addr = ea; v.e_req = er; v.e_v = ev;
      v.e_ir = eir; v.e_npc = enpc; v.e_mis = em;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] ea, input logic er, input logic ev,
                      input logic [31:0] eir, input logic [63:0] enpc, input logic em);
      n_vec++;
      if ({IMEM_ADDR, IMEM_REQ, DE_V, DE_IR, DE_NPC, FETCH_MISALIGN} !== {ea, er, ev, eir, enpc, em}) begin
         n_bad++;
         $display("FAIL %s: got addr=%h req=%b v=%b ir=%h npc=%h mis=%b, want addr=%h req=%b v=%b ir=%h npc=%h mis=%b",
                  name, IMEM_ADDR, IMEM_REQ, DE_V, DE_IR, DE_NPC, FETCH_MISALIGN, ea, er, ev, eir, enpc, em);
      end
   endtask

   // Reference model: instruction-level view (pending branch flag, queue of parked words).
   logic [63:0] m_pc, m_npc;
   logic [31:0] m_ir;
   logic        m_v, m_mis, m_br;
   logic [31:0] m_held[$];

   task automatic m_deliver(input logic [31:0] w);
      m_ir  = w;
      m_pc  = m_pc + 64'd4;
      m_npc = m_pc;
      m_v   = 1'b1;
      m_br  = (w[6:0] == 7'h63);
   endtask

   task automatic m_redirect(input logic [63:0] t);
      m_pc  = t;
      m_mis = (t[1:0] != 2'b00);
   endtask

   task automatic m_step();
      if (DE_CS) begin
         m_redirect(DE_MTVEC);
         m_v = 1'b0; m_br = 1'b0; m_held.delete();
      end else if (m_br) begin
         if (!V_MEM_STALL) m_v = 1'b0;
         if (BR_RESOLVE) begin
            if (BR_TAKEN) m_redirect(BR_TARGET);
            m_br = 1'b0;
         end
      end else if (m_held.size() != 0) begin
         if (!V_MEM_STALL) m_deliver(m_held.pop_front());
      end else if (m_mis) begin
         m_v = 1'b0;
      end else if (IMEM_RDY) begin
         if (V_MEM_STALL) m_held.push_back(IMEM_DATA);
         else             m_deliver(IMEM_DATA);
      end else if (!V_MEM_STALL) begin
         m_v = 1'b0;
      end
   endtask

   initial begin
      //       rdy data stall brr brt tgt           cs mtvec                 e_addr                 req v  ir  npc                    mis
      tv.push_back(mk(1, I1, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h1004,              1, 1, I1, 64'h1004,              0));
      tv.push_back(mk(1, I2, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h1008,              1, 1, I2, 64'h1008,              0));
      tv.push_back(mk(0, I3, 1, 0, 0, 64'h0,    0, 64'h0,                 64'h1008,              1, 1, I2, 64'h1008,              0));
      tv.push_back(mk(0, I3, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h1008,              1, 0, I2, 64'h1008,              0));
      tv.push_back(mk(1, I3, 1, 0, 0, 64'h0,    0, 64'h0,                 64'h1008,              0, 0, I2, 64'h1008,              0));
      tv.push_back(mk(0, I1, 1, 0, 0, 64'h0,    0, 64'h0,                 64'h1008,              0, 0, I2, 64'h1008,              0));
      tv.push_back(mk(1, I1, 1, 0, 0, 64'h0,    0, 64'h0,                 64'h1008,              0, 0, I2, 64'h1008,              0));
      tv.push_back(mk(0, I1, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h100c,              1, 1, I3, 64'h100c,              0));
      tv.push_back(mk(1, BR, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h1010,              0, 1, BR, 64'h1010,              0));
      tv.push_back(mk(0, I1, 1, 0, 0, 64'h0,    0, 64'h0,                 64'h1010,              0, 1, BR, 64'h1010,              0));
      tv.push_back(mk(0, I1, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h1010,              0, 0, BR, 64'h1010,              0));
      tv.push_back(mk(0, I1, 0, 1, 1, 64'h3000, 0, 64'h0,                 64'h3000,              1, 0, BR, 64'h1010,              0));
      tv.push_back(mk(1, BR, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h3004,              0, 1, BR, 64'h3004,              0));
      tv.push_back(mk(0, I1, 0, 1, 0, 64'h3000, 0, 64'h0,                 64'h3004,              1, 0, BR, 64'h3004,              0));
      tv.push_back(mk(1, I1, 0, 0, 0, 64'h0,    1, 64'h8000_0000,         64'h8000_0000,         1, 0, BR, 64'h3004,              0));
      tv.push_back(mk(1, I1, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h8000_0004,         1, 1, I1, 64'h8000_0004,         0));
      tv.push_back(mk(1, BR, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h8000_0008,         0, 1, BR, 64'h8000_0008,         0));
      tv.push_back(mk(0, I1, 0, 1, 1, 64'h3002, 0, 64'h0,                 64'h3002,              0, 0, BR, 64'h8000_0008,         1));
      tv.push_back(mk(1, I2, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h3002,              0, 0, BR, 64'h8000_0008,         1));
      tv.push_back(mk(0, I2, 0, 0, 0, 64'h0,    1, 64'h100,               64'h100,               1, 0, BR, 64'h8000_0008,         0));
      tv.push_back(mk(1, I2, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h104,               1, 1, I2, 64'h104,               0));
      tv.push_back(mk(0, I2, 0, 1, 1, 64'h5000, 0, 64'h0,                 64'h104,               1, 0, I2, 64'h104,               0));
      tv.push_back(mk(0, I2, 0, 0, 0, 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, I2, 64'h104,          0));
      tv.push_back(mk(1, I3, 0, 0, 0, 64'h0,    0, 64'h0,                 64'h0,                 1, 1, I3, 64'h0,                 0));

      // Reset state, including a request-capable pattern on IMEM_RDY.
      IMEM_RDY = 1'b1; IMEM_DATA = I1;
      repeat (3) @(posedge CLK);
      #1 chk("reset_state", 64'h1000, 0, 0, 32'h0, 64'h0, 0);
      IMEM_RDY = 1'b0;
      RESET = 1'b0;
      #1 chk("first_issue", 64'h1000, 1, 0, 32'h0, 64'h0, 0);

      foreach (tv[i]) begin
         IMEM_RDY = tv[i].rdy; IMEM_DATA = tv[i].data; V_MEM_STALL = tv[i].stall;
         BR_RESOLVE = tv[i].brr; BR_TAKEN = tv[i].brt; BR_TARGET = tv[i].tgt;
         DE_CS = tv[i].cs; DE_MTVEC = tv[i].mtvec;
         @(posedge CLK); #1;
         chk($sformatf("vec%0d", i), tv[i].e_addr, tv[i].e_req, tv[i].e_v, tv[i].e_ir, tv[i].e_npc, tv[i].e_mis);
      end

      // Reset mid-request: outputs clear asynchronously, RDY during reset ignored.
      IMEM_RDY = 1'b0; V_MEM_STALL = 1'b0; BR_RESOLVE = 1'b0; DE_CS = 1'b0;
      @(posedge CLK); #3;
      RESET = 1'b1;
      #1 chk("async_reset", 64'h1000, 0, 0, 32'h0, 64'h0, 0);
      IMEM_RDY = 1'b1; IMEM_DATA = I2;
      @(posedge CLK); @(posedge CLK); #1;
      chk("rdy_in_reset", 64'h1000, 0, 0, 32'h0, 64'h0, 0);
      RESET = 1'b0; IMEM_DATA = I1;
      #1 chk("reset_release", 64'h1000, 1, 0, 32'h0, 64'h0, 0);
      @(posedge CLK); #1;
      chk("post_reset_fetch", 64'h1004, 1, 1, I1, 64'h1004, 0);

      // Random traffic against the reference model.
      m_pc = 64'h1004; m_npc = 64'h1004; m_ir = I1; m_v = 1'b1; m_mis = 1'b0; m_br = 1'b0;
      m_held.delete();
      for (int c = 0; c < 3000; c++) begin
         IMEM_RDY    = ($urandom_range(0, 9) < 7);
         IMEM_DATA   = $urandom;
         if ($urandom_range(0, 3) == 0) IMEM_DATA[6:0] = 7'b1100011;
         V_MEM_STALL = ($urandom_range(0, 3) == 0);
         BR_RESOLVE  = ($urandom_range(0, 9) < 3);
         BR_TAKEN    = $urandom_range(0, 1);
         BR_TARGET   = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) BR_TARGET[1:0] = 2'b00;
         DE_CS       = ($urandom_range(0, 15) == 0);
         DE_MTVEC    = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) DE_MTVEC[1:0] = 2'b00;
         @(posedge CLK); #1;
         m_step();
         chk($sformatf("rand%0d", c), m_pc, !m_br && (m_held.size() == 0) && !m_mis, m_v, m_ir, m_npc, m_mis);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
